bpi_flash_responder: RTL
========================

// Module: bpi_flash_responder
// PURPOSE
//  Synthesizable BPI parallel NOR flash device: the responder end of the BPI bus driven by the AXI-to-BPI controller.
//  Answers async-mode reads and an Intel-style command set from a small internal word array.
//  Used as an on-chip flash stand-in for controller bring-up and loopback tests.
//  All bus strobes are sampled on clk; it shares the controller's clock domain.
// PARAMETERS
//  C_MEM_WIDTH       16   data word width in bits (8 or 16)
//  C_ADDR_WIDTH      10   word address width; array depth = 2**C_ADDR_WIDTH words
//  C_BLOCK_WORDS     64   erase block size in words (power of two, <= depth)
//  C_OE_LATENCY      2    cycles from sampled OE/CE low to valid DQ (1..5)
//  C_PROGRAM_CYCLES  16   busy cycles per word program (>= 1)
//  C_DEVICE_ID       16'h8962  device ID returned in ID mode
// PORTS
//  clk        in   1             clock
//  rst        in   1             asynchronous reset, active-high
//  bpi_a      in   C_ADDR_WIDTH  word address
//  bpi_dq_i   in   C_MEM_WIDTH   data from controller
//  bpi_dq_o   out  C_MEM_WIDTH   data to controller
//  bpi_dq_t   out  C_MEM_WIDTH   tristate control, 1 = high-Z (all bits equal)
//  bpi_adv    in   1             address valid, active-low; address latched while low, held while high
//  bpi_ce_n   in   1             chip enable, active-low
//  bpi_oe_n   in   1             output enable, active-low
//  bpi_we_n   in   1             write enable, active-low
//  busy       out  1             program/erase in progress (status bit 7 inverted)
// BEHAVIOUR
//  Reset: bpi_dq_t all 1, bpi_dq_o 0, busy 0, status 8'h80, state READ_ARRAY, OE pipeline cleared.
//   Array contents are not reset. Array initialises to all ones (erased) at configuration.
//  Read: ce_n=0 & oe_n=0 sampled at cycle n -> dq_t=0 and dq_o valid from n+C_OE_LATENCY.
//   Data tracks the latched address with the same latency. Any of ce_n/oe_n sampled high -> dq_t=1 next cycle.
//   Output data source per state:
//    READ_ARRAY = array word.
//    READ_STATUS, PROGRAMMING, ERASING, PROG_SETUP, ERASE_SETUP = status, zero-extended.
//    READ_ID = ID data.
//  Write cycle: ce_n=0 and we_n sampled 0 then 1 (rising edge). Address and bpi_dq_i are captured at that edge.
//   Only the low 8 data bits are decoded as a command. Write edges while oe_n=0 are ignored.
//  States and command (cmd) transitions:
//   READ_ARRAY/READ_STATUS/READ_ID:
//    8'hFF -> READ_ARRAY; 8'h70 -> READ_STATUS; 8'h50 -> clear status bits 5,4 (state unchanged);
//    8'h40 -> PROG_SETUP; 8'h20 -> ERASE_SETUP; others ignored.
//   PROG_SETUP: next write -> PROGRAMMING. Array word becomes old & data (bits only clear).
//   ERASE_SETUP: next write with cmd 8'hD0 -> ERASING on the block of the captured address.
//    Any other cmd sets status bits 5 and 4 (sequence error) and goes to READ_STATUS.
//   PROGRAMMING: busy for C_PROGRAM_CYCLES, then READ_STATUS.
//    If the programmed word does not equal data, set status bit 4.
//   ERASING: writes one word per cycle at all ones, block-aligned address ascending; C_BLOCK_WORDS cycles, then READ_STATUS.
//   While busy, all write cycles are ignored (no error).
//  Status: bit7 ready (0 while busy), bit5 erase error, bit4 program error, others 0. Bits 5/4 are sticky until 8'h50.
//  Address wrap: the erase block index is address / C_BLOCK_WORDS; the erase counter never crosses the block end.
//  A write edge and a busy-done event in the same cycle: busy-done wins, the write is dropped.
//  Reset mid-program/erase: operation aborted. Words already written stay written; the rest are unchanged.
// CONFIGURATION
//  BPI_RESP_ID_EN defined:
//   cmd 8'h90 -> READ_ID. Reads return 16'h0089 at word address 0, C_DEVICE_ID at 1, 0 elsewhere.
//  BPI_RESP_ID_EN undefined:
//   8'h90 is an unknown command and is ignored (no state change, no error). READ_ID logic is absent.
// TESTING
//  Reset, then read address 3 with oe_n/ce_n low -> dq_t=0 after 2 cycles, dq_o=16'hFFFF. Deassert oe_n -> dq_t=1 next cycle.
//  Program sequence, then read addr 5:
//   Write 16'h0040 then 16'hA5A5 at addr 5 -> busy=1 for 16 cycles. Status read = 16'h0000 while busy, then 16'h0080.
//   Write 8'hFF, read addr 5 -> 16'hA5A5.
//  Reprogram, then erase:
//   Program 16'hFF0F over 16'hA5A5 -> word 16'hA505, status 16'h0090.
//   8'h50 -> status 16'h0080.
//  Erase at addr 70: 8'h20 then 8'hD0 -> busy 64 cycles; addrs 64..127 read 16'hFFFF; addr 5 unchanged.
//  Bad erase: 8'h20 then 8'h10 -> status 16'hB0, no array change. Reset asserted mid-erase -> status 16'h80, busy=0.
//  ID mode, with BPI_RESP_ID_EN: 8'h90, then reads of addr 0/1 -> 16'h0089 / 16'h8962.
//   Without the macro: same stimulus reads array data 16'hFFFF.

Source files
------------

// File: rtl/bpi_flash_responder.sv
// BPI parallel NOR flash responder: async-mode reads plus Intel-style program/erase/status commands.
// Define BPI_RESP_ID_EN to enable the 8'h90 READ_ID mode (manufacturer/device ID reads).
module bpi_flash_responder #(
    parameter int          C_MEM_WIDTH      = 16,
    parameter int          C_ADDR_WIDTH     = 10,
    parameter int          C_BLOCK_WORDS    = 64,
    parameter int          C_OE_LATENCY     = 2,
    parameter int          C_PROGRAM_CYCLES = 16,
    parameter logic [15:0] C_DEVICE_ID      = 16'h8962
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [C_ADDR_WIDTH-1:0] bpi_a,
    input  logic [C_MEM_WIDTH-1:0]  bpi_dq_i,
    output logic [C_MEM_WIDTH-1:0]  bpi_dq_o,
    output logic [C_MEM_WIDTH-1:0]  bpi_dq_t,
    input  logic                    bpi_adv,
    input  logic                    bpi_ce_n,
    input  logic                    bpi_oe_n,
    input  logic                    bpi_we_n,
    output logic                    busy
);
    localparam int DEPTH = 1 << C_ADDR_WIDTH;
    localparam int PCW   = $clog2(C_PROGRAM_CYCLES + 1);
    localparam int LCW   = $clog2(C_OE_LATENCY + 1);
    localparam logic [C_ADDR_WIDTH-1:0] BLK_MASK  = C_ADDR_WIDTH'(C_BLOCK_WORDS - 1);
    localparam logic [PCW-1:0]          PROG_LOAD = PCW'(C_PROGRAM_CYCLES - 1);
    localparam logic [LCW-1:0]          OE_LAST   = LCW'(C_OE_LATENCY - 1);

    typedef enum logic [2:0] {
        ST_READ_ARRAY,
        ST_READ_STATUS,
        ST_PROG_SETUP,
        ST_ERASE_SETUP,
        ST_PROGRAMMING,
        ST_ERASING
`ifdef BPI_RESP_ID_EN
        , ST_READ_ID
`endif
    } state_t;

    state_t                    state;
    state_t                    state_next;
    // Words are stored inverted so a zero-initialised RAM reads back as erased (all ones).
    logic [C_MEM_WIDTH-1:0]    mem_n [DEPTH];
    logic [C_ADDR_WIDTH-1:0]   addr_lat;
    logic [C_ADDR_WIDTH-1:0]   eff_addr;
    logic                      we_prev;
    logic                      wr_edge;
    logic                      rd_active;
    logic [7:0]                cmd;
    logic [7:0]                status;
    logic                      err_erase;
    logic                      err_prog;
    logic                      prog_fail;
    logic [PCW-1:0]            prog_cnt;
    logic [C_ADDR_WIDTH-1:0]   erase_base;
    logic [C_ADDR_WIDTH-1:0]   erase_cnt;
    logic [LCW-1:0]            oe_cnt;
    logic [C_MEM_WIDTH-1:0]    rd_data;
    logic [C_MEM_WIDTH-1:0]    rd_pipe [C_OE_LATENCY];
    logic                      prog_start;
    logic                      prog_done;
    logic                      erase_start;
    logic                      erase_step;
    logic                      seq_err;
    logic                      clr_err;

    assign eff_addr  = bpi_adv ? addr_lat : bpi_a;
    assign rd_active = !bpi_ce_n && !bpi_oe_n;
    assign wr_edge   = !we_prev && bpi_we_n && !bpi_ce_n && bpi_oe_n;
    assign cmd       = bpi_dq_i[7:0];
    assign status    = {!busy, 1'b0, err_erase, err_prog, 4'b0000};
    assign bpi_dq_o  = rd_pipe[C_OE_LATENCY-1];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_READ_ARRAY;
        end else begin
            state <= state_next;
        end
    end

    // Command decoder and operation sequencing.
    always_comb begin
        state_next  = state;
        prog_start  = 1'b0;
        prog_done   = 1'b0;
        erase_start = 1'b0;
        erase_step  = 1'b0;
        seq_err     = 1'b0;
        clr_err     = 1'b0;
        case (state)
            ST_READ_ARRAY, ST_READ_STATUS
`ifdef BPI_RESP_ID_EN
            , ST_READ_ID
`endif
            : begin
                if (wr_edge) begin
                    case (cmd)
                        8'hFF:   state_next = ST_READ_ARRAY;
                        8'h70:   state_next = ST_READ_STATUS;
                        8'h50:   clr_err    = 1'b1;
                        8'h40:   state_next = ST_PROG_SETUP;
                        8'h20:   state_next = ST_ERASE_SETUP;
`ifdef BPI_RESP_ID_EN
                        8'h90:   state_next = ST_READ_ID;
`endif
                        default: state_next = state;
                    endcase
                end else begin
                    state_next = state;
                end
            end
            ST_PROG_SETUP: begin
                if (wr_edge) begin
                    state_next = ST_PROGRAMMING;
                    prog_start = 1'b1;
                end else begin
                    state_next = state;
                end
            end
            ST_ERASE_SETUP: begin
                if (wr_edge && cmd == 8'hD0) begin
                    state_next  = ST_ERASING;
                    erase_start = 1'b1;
                end else if (wr_edge) begin
                    state_next = ST_READ_STATUS;
                    seq_err    = 1'b1;
                end else begin
                    state_next = state;
                end
            end
            ST_PROGRAMMING: begin
                if (prog_cnt == PCW'(0)) begin
                    state_next = ST_READ_STATUS;
                    prog_done  = 1'b1;
                end else begin
                    state_next = state;
                end
            end
            ST_ERASING: begin
                erase_step = 1'b1;
                if (erase_cnt == BLK_MASK) begin
                    state_next = ST_READ_STATUS;
                end else begin
                    state_next = state;
                end
            end
            default: state_next = ST_READ_ARRAY;
        endcase
    end

    // Array write port: program clears bits, erase sweeps the block one word per cycle.
    always_ff @(posedge clk) begin
        if (prog_start) begin
            mem_n[eff_addr] <= mem_n[eff_addr] | ~bpi_dq_i;
        end else if (erase_step) begin
            mem_n[erase_base | erase_cnt] <= {C_MEM_WIDTH{1'b0}};
        end
    end

    // Bus sampling, operation counters and sticky error bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_prev    <= 1'b1;
            addr_lat   <= {C_ADDR_WIDTH{1'b0}};
            prog_cnt   <= PCW'(0);
            prog_fail  <= 1'b0;
            erase_base <= {C_ADDR_WIDTH{1'b0}};
            erase_cnt  <= {C_ADDR_WIDTH{1'b0}};
            err_erase  <= 1'b0;
            err_prog   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            we_prev <= bpi_we_n;
            busy    <= (state_next == ST_PROGRAMMING) || (state_next == ST_ERASING);
            if (!bpi_adv) begin
                addr_lat <= bpi_a;
            end
            if (prog_start) begin
                prog_cnt  <= PROG_LOAD;
                prog_fail <= |(mem_n[eff_addr] & bpi_dq_i);
            end else if (state == ST_PROGRAMMING && prog_cnt != PCW'(0)) begin
                prog_cnt <= prog_cnt - PCW'(1);
            end
            if (erase_start) begin
                erase_base <= eff_addr & ~BLK_MASK;
                erase_cnt  <= {C_ADDR_WIDTH{1'b0}};
            end else if (erase_step && erase_cnt != BLK_MASK) begin
                erase_cnt <= erase_cnt + C_ADDR_WIDTH'(1);
            end
            if (clr_err) begin
                err_erase <= 1'b0;
                err_prog  <= 1'b0;
            end else if (seq_err) begin
                err_erase <= 1'b1;
                err_prog  <= 1'b1;
            end else if (prog_done && prog_fail) begin
                err_prog <= 1'b1;
            end
        end
    end

`ifdef BPI_RESP_ID_EN
    logic [15:0] id_word;

    // Manufacturer/device ID words.
    always_comb begin
        if (eff_addr == C_ADDR_WIDTH'(0)) begin
            id_word = 16'h0089;
        end else if (eff_addr == C_ADDR_WIDTH'(1)) begin
            id_word = C_DEVICE_ID;
        end else begin
            id_word = 16'h0000;
        end
    end
`endif

    // Read data source selected by the current mode.
    always_comb begin
        rd_data = C_MEM_WIDTH'(status);
        case (state)
            ST_READ_ARRAY: rd_data = ~mem_n[eff_addr];
`ifdef BPI_RESP_ID_EN
            ST_READ_ID:    rd_data = id_word[C_MEM_WIDTH-1:0];
`endif
            default:       rd_data = C_MEM_WIDTH'(status);
        endcase
    end

    // Output-enable latency: drive DQ only after CE/OE held low for C_OE_LATENCY samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oe_cnt   <= LCW'(0);
            bpi_dq_t <= {C_MEM_WIDTH{1'b1}};
            for (int i = 0; i < C_OE_LATENCY; i++) begin
                rd_pipe[i] <= {C_MEM_WIDTH{1'b0}};
            end
        end else begin
            if (!rd_active) begin
                oe_cnt   <= LCW'(0);
                bpi_dq_t <= {C_MEM_WIDTH{1'b1}};
            end else if (oe_cnt == OE_LAST) begin
                bpi_dq_t <= {C_MEM_WIDTH{1'b0}};
            end else begin
                oe_cnt   <= oe_cnt + LCW'(1);
                bpi_dq_t <= {C_MEM_WIDTH{1'b1}};
            end
            rd_pipe[0] <= rd_data;
            for (int i = 1; i < C_OE_LATENCY; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
        end
    end
endmodule
